// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO bus sequencer.
//   IO_BASE      - base of the 1 KiB peripheral window at the top of the address space
//   DEAD_DATA    - load data returned when a read transaction times out
//   StIdle/StBusy/StDone - sequencer state encodings
//   ERR_TIMEOUT/ERR_CONFLICT - bit positions in the sticky error register
package mmio_pkg;

    localparam logic [31:0] IO_BASE   = 32'hFFFF_FC00;
    localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_CONFLICT = 1;

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational decode of a CPU byte address into the peripheral window.
// Ports:
//   cpu_addr  in   byte address from the ALU
//   in_window out  1 when cpu_addr falls in IO_BASE..0xFFFFFFFF
//   index     out  device index, cpu_addr[9:8]
//   offset    out  word offset inside the device, cpu_addr[7:2]
//   sel       out  one-hot device select derived from index (all zero if index >= N_DEV)
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned N_DEV  = 4
) (
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              in_window,
    output logic [1:0]        index,
    output logic [5:0]        offset,
    output logic [N_DEV-1:0]  sel
);

    // Byte lane bits play no part in a word-addressed peripheral access.
    logic unused_byte_lane;
    assign unused_byte_lane = ^cpu_addr[1:0];

    assign in_window = (cpu_addr[ADDR_W-1:10] == IO_BASE[ADDR_W-1:10]);
    assign index     = cpu_addr[9:8];
    assign offset    = cpu_addr[7:2];

    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            sel[i] = (index == 2'(i));
        end
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: turns single-cycle IORead/IOWrite strobes from the MEM stage into a
// req/ack transaction with one of N_DEV peripherals, stalling the CPU until the
// peripheral acknowledges or the wait counter reaches TIMEOUT.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   cpu_io_read/write    IO strobes from instruction control
//   cpu_addr, cpu_wdata  address (ALU result) and store data (rs2)
//   cpu_rdata            load data to the writeback mux, held until the next read completes
//   cpu_stall            freezes PC and pipeline registers
//   dev_req/we/sel       request, direction and one-hot select to the peripherals
//   dev_offset/wdata     latched word offset and store data
//   dev_rdata, dev_ack   per-device read data and completion pulses
//   err, err_clr         sticky {conflict, timeout} flags and their synchronous clear
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_DEV   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_io_read,
    input  logic                    cpu_io_write,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_stall,
    output logic                    dev_req,
    output logic                    dev_we,
    output logic [N_DEV-1:0]        dev_sel,
    output logic [5:0]              dev_offset,
    output logic [DATA_W-1:0]       dev_wdata,
    input  logic [N_DEV*DATA_W-1:0] dev_rdata,
    input  logic [N_DEV-1:0]        dev_ack,
    output logic [1:0]              err,
    input  logic                    err_clr
);

    // Count value seen during the last permitted BUSY cycle.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic              dec_in_window;
    logic [1:0]        dec_index;
    logic [5:0]        dec_offset;
    logic [N_DEV-1:0]  dec_sel;

    logic [1:0]        state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic              we_q, we_d;
    logic [1:0]        idx_q, idx_d;
    logic [N_DEV-1:0]  sel_q, sel_d;
    logic [5:0]        offset_q, offset_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    logic              req_valid;
    logic              ack_hit;
    logic [DATA_W-1:0] ack_data;

    mmio_addr_decode #(
        .ADDR_W (ADDR_W),
        .N_DEV  (N_DEV)
    ) u_decode (
        .cpu_addr  (cpu_addr),
        .in_window (dec_in_window),
        .index     (dec_index),
        .offset    (dec_offset),
        .sel       (dec_sel)
    );

    assign req_valid = (cpu_io_read | cpu_io_write) & dec_in_window;

    // Only the selected device's ack counts; stray acks from other devices are masked.
    always_comb begin
        ack_hit  = |(dev_ack & sel_q);
        ack_data = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (idx_q == 2'(i)) begin
                ack_data = dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        we_d     = we_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        offset_d = offset_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        // Clear first so that any set event below overrides it in the same cycle.
        err_d    = err_clr ? 2'b00 : err_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d  = StBusy;
                    count_d  = '0;
                    // A read+write conflict resolves to a write.
                    we_d     = cpu_io_write;
                    idx_d    = dec_index;
                    sel_d    = dec_sel;
                    offset_d = dec_offset;
                    wdata_d  = cpu_wdata;
                    if (cpu_io_read && cpu_io_write) begin
                        err_d[ERR_CONFLICT] = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
                // Ack takes priority over timeout, including in the final count cycle.
                if (ack_hit) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = ack_data;
                    end
                end else if (count_q == LAST_CNT) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = DATA_W'(DEAD_DATA);
                    end
                    err_d[ERR_TIMEOUT] = 1'b1;
                end
            end
            // Strobes seen here belong to the instruction now committing.
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            sel_q    <= '0;
            offset_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Stall is combinational so the requesting cycle itself is frozen.
    assign cpu_stall  = ((state_q == StIdle) & req_valid) | (state_q == StBusy);
    assign dev_req    = (state_q == StBusy);
    assign dev_we     = (state_q == StBusy) & we_q;
    assign dev_sel    = (state_q == StBusy) ? sel_q : '0;
    assign dev_offset = offset_q;
    assign dev_wdata  = wdata_q;
    assign cpu_rdata  = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Testbench for mmio_bus_ctrl: a table of directed transactions, randomized transactions
// checked against a transaction-level model, and hand sequences for reset behaviour.
module tb_mmio_bus_ctrl;

    localparam int          TO   = 255;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_io_read = 1'b0;
    logic         cpu_io_write = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         dev_req;
    logic         dev_we;
    logic [3:0]   dev_sel;
    logic [5:0]   dev_offset;
    logic [31:0]  dev_wdata;
    logic [127:0] dev_rdata = '0;
    logic [3:0]   dev_ack = '0;
    logic [1:0]   err;
    logic         err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_bus_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .N_DEV   (4),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_io_read  (cpu_io_read),
        .cpu_io_write (cpu_io_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .dev_req      (dev_req),
        .dev_we       (dev_we),
        .dev_sel      (dev_sel),
        .dev_offset   (dev_offset),
        .dev_wdata    (dev_wdata),
        .dev_rdata    (dev_rdata),
        .dev_ack      (dev_ack),
        .err          (err),
        .err_clr      (err_clr)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;     // BUSY cycle (1-based) carrying the ack; 0 = never
        logic [31:0] rval;
        logic [3:0]  noise;     // acks raised on unselected devices every BUSY cycle
        logic        clr;       // err_clr during the request cycle
        logic        hold;      // keep strobes high through DONE
        int          exp_stall;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one CPU IO instruction starting at posedge+1 of an IDLE cycle, acts as the
    // peripheral, and returns at posedge+1 of the following IDLE cycle.
    task automatic run_txn(input string name, input vec_t v);
        logic       valid;
        int         dev;
        logic [3:0] exp_sel;
        int         stalls;
        int         k;
        logic       bad;
        valid   = (v.rd | v.wr) && (v.addr[31:10] == 22'h3F_FFFF);
        dev     = int'(v.addr[9:8]);
        exp_sel = 4'(1 << dev);
        stalls  = 0;
        bad     = 1'b0;

        cpu_io_read  = v.rd;
        cpu_io_write = v.wr;
        cpu_addr     = v.addr;
        cpu_wdata    = v.wdata;
        err_clr      = v.clr;
        #4;
        chk({name, " req_stall"}, 32'(cpu_stall), 32'(valid));
        chk({name, " req_noreq"}, 32'(dev_req), 32'd0);
        if (valid) stalls = 1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        if (!v.hold) begin
            cpu_io_read  = 1'b0;
            cpu_io_write = 1'b0;
        end

        if (valid) begin
            k = 1;
            while (1) begin
                dev_ack = v.noise & ~exp_sel;
                if (k == v.delay) dev_ack = dev_ack | exp_sel;
                for (int i = 0; i < 4; i++) dev_rdata[i*32 +: 32] = $urandom;
                dev_rdata[dev*32 +: 32] = v.rval;
                #4;
                if (!cpu_stall) break;
                stalls++;
                if (dev_req !== 1'b1 || dev_sel !== exp_sel || dev_we !== v.wr ||
                    dev_offset !== v.addr[7:2] || (v.wr && dev_wdata !== v.wdata))
                    bad = 1'b1;
                if (k >= 300) break;
                @(posedge clk); #1;
                k++;
            end
            chk({name, " busy_hold"}, 32'(bad), 32'd0);
            chk({name, " stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
            chk({name, " done_req"}, 32'(dev_req), 32'd0);
            chk({name, " rdata"}, cpu_rdata, v.exp_rdata);
            chk({name, " err"}, 32'(err), 32'(v.exp_err));
            @(posedge clk); #1;
            dev_ack = '0;
            if (v.hold) begin
                cpu_io_read  = 1'b0;
                cpu_io_write = 1'b0;
                #4;
                chk({name, " after_done_stall"}, 32'(cpu_stall), 32'd0);
                chk({name, " after_done_req"}, 32'(dev_req), 32'd0);
                @(posedge clk); #1;
            end
        end else begin
            #4;
            chk({name, " ign_req"}, 32'(dev_req), 32'd0);
            chk({name, " ign_stall"}, 32'(cpu_stall), 32'd0);
            chk({name, " rdata"}, cpu_rdata, v.exp_rdata);
            chk({name, " err"}, 32'(err), 32'(v.exp_err));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t        v;
        logic [31:0] m_rdata;
        logic [1:0]  m_err;
        int          p;
        logic [1:0]  s;

        //           rd wr addr          wdata        dly rval          noise   clr hold stall rdata         err
        tbl[0]  = '{1'b1, 1'b0, 32'hFFFF_FE08, 32'h0,        1,   32'h0000_00A5, 4'b0000, 1'b0, 1'b0, 2,   32'h0000_00A5, 2'b00};
        tbl[1]  = '{1'b0, 1'b1, 32'hFFFF_FC04, 32'h1234,     5,   32'h1111_1111, 4'b0000, 1'b0, 1'b0, 6,   32'h0000_00A5, 2'b00};
        tbl[2]  = '{1'b1, 1'b0, 32'hFFFF_FF00, 32'h0,        0,   32'h2222_2222, 4'b0000, 1'b0, 1'b0, 256, DEAD,          2'b01};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,        1,   32'h3333_3333, 4'b0000, 1'b1, 1'b0, 0,   DEAD,          2'b00};
        tbl[4]  = '{1'b1, 1'b0, 32'hFFFF_FD0C, 32'h0,        255, 32'hCAFE_0001, 4'b0000, 1'b0, 1'b0, 256, 32'hCAFE_0001, 2'b00};
        tbl[5]  = '{1'b1, 1'b1, 32'hFFFF_FD00, 32'h55AA,     2,   32'h4444_4444, 4'b0000, 1'b0, 1'b0, 3,   32'hCAFE_0001, 2'b10};
        tbl[6]  = '{1'b0, 1'b1, 32'hFFFF_FE40, 32'h77,       3,   32'h5555_5555, 4'b0000, 1'b0, 1'b1, 4,   32'hCAFE_0001, 2'b10};
        tbl[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        4,   32'h0BAD_F00D, 4'b0111, 1'b0, 1'b0, 5,   32'h0BAD_F00D, 2'b10};
        tbl[8]  = '{1'b1, 1'b0, 32'hFFFF_FE10, 32'h0,        0,   32'h6666_6666, 4'b1011, 1'b0, 1'b0, 256, DEAD,          2'b11};
        tbl[9]  = '{1'b1, 1'b1, 32'hFFFF_FE00, 32'h9999,     1,   32'h7777_7777, 4'b0000, 1'b1, 1'b0, 2,   DEAD,          2'b10};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_2000, 32'hAAAA,     1,   32'h8888_8888, 4'b0000, 1'b0, 1'b0, 0,   DEAD,          2'b10};
        tbl[11] = '{1'b1, 1'b0, 32'hFFFF_FC00, 32'h0,        1,   32'h1357_9BDF, 4'b1110, 1'b0, 1'b0, 2,   32'h1357_9BDF, 2'b10};

        // Reset state.
        #12;
        chk("rst cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst dev_req", 32'(dev_req), 32'd0);
        chk("rst dev_we", 32'(dev_we), 32'd0);
        chk("rst dev_sel", 32'(dev_sel), 32'd0);
        chk("rst dev_offset", 32'(dev_offset), 32'd0);
        chk("rst dev_wdata", dev_wdata, 32'd0);
        chk("rst cpu_rdata", cpu_rdata, 32'd0);
        chk("rst err", 32'(err), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 12; r++) begin
            run_txn($sformatf("tbl%0d", r), tbl[r]);
        end

        // Randomized transactions against a transaction-level model.
        m_rdata = tbl[11].exp_rdata;
        m_err   = tbl[11].exp_err;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) v.addr = $urandom & 32'h7FFF_FFFF;
            else v.addr = {22'h3F_FFFF, 10'($urandom)};
            s       = 2'($urandom_range(0, 3));
            v.rd    = s[0];
            v.wr    = s[1];
            v.wdata = $urandom;
            v.rval  = $urandom;
            p       = int'($urandom_range(0, 19));
            v.delay = (p == 0) ? 0 : (p == 1) ? TO : int'($urandom_range(1, 8));
            v.noise = 4'($urandom);
            v.clr   = ($urandom_range(0, 7) == 0);
            v.hold  = ($urandom_range(0, 3) == 0);

            if (v.clr) m_err = 2'b00;
            if ((v.rd | v.wr) && (&v.addr[31:10])) begin
                if (v.rd && v.wr) m_err[1] = 1'b1;
                v.exp_stall = 1 + ((v.delay == 0) ? TO : v.delay);
                if (!v.wr) m_rdata = (v.delay == 0) ? DEAD : v.rval;
                if (v.delay == 0) m_err[0] = 1'b1;
            end else begin
                v.exp_stall = 0;
            end
            v.exp_rdata = m_rdata;
            v.exp_err   = m_err;
            run_txn($sformatf("rnd%0d", n), v);
        end

        // Reset asserted in the third BUSY cycle of a read.
        cpu_io_read = 1'b1;
        cpu_addr    = 32'hFFFF_FD04;
        @(posedge clk); #1;
        cpu_io_read = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        chk("midrst pre_stall", 32'(cpu_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst stall", 32'(cpu_stall), 32'd0);
        chk("midrst req", 32'(dev_req), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        #4;
        chk("postrst rdata", cpu_rdata, 32'd0);
        chk("postrst err", 32'(err), 32'd0);
        chk("postrst stall", 32'(cpu_stall), 32'd0);
        chk("postrst req", 32'(dev_req), 32'd0);
        @(posedge clk); #1;

        // Controller is usable again after reset.
        v = tbl[0];
        run_txn("postrst txn", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
